// File: rtl/alu_out_result_collector.sv
// rtl/alu_out_result_collector.sv - multi-channel ALU result capture, round-robin arbitration, output FIFO
// Per-channel holding registers feed a shared FIFO; conflicting strobes are counted as drops.
module alu_out_result_collector #(
  parameter int NUM_CH       = 2,
  parameter int RESULT_WIDTH = 16,
  parameter int DEPTH        = 8,
  parameter int CNT_WIDTH    = 16,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int AW          = $clog2(DEPTH),
  localparam int LW          = AW + 1
) (
  input  logic                           alu_clk,
  input  logic                           alu_rst,
  input  logic [NUM_CH-1:0]              done,
  input  logic [NUM_CH*RESULT_WIDTH-1:0] result,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [RESULT_WIDTH-1:0]        out_result,
  output logic [CH_W-1:0]                out_ch,
  output logic [LW-1:0]                  level,
  output logic                           full,
  output logic                           empty,
  output logic [CNT_WIDTH-1:0]           drop_count,
  input  logic                           clear_drops
);

  localparam int EW = CH_W + RESULT_WIDTH;
  localparam int SW = CNT_WIDTH + 4;

  logic [NUM_CH-1:0]       hold_v_q, hold_v_d;
  logic [RESULT_WIDTH-1:0] hold_d_q [NUM_CH];
  logic [EW-1:0]           mem_q [DEPTH];
  logic [CH_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]           level_q, level_d;
  logic [CNT_WIDTH-1:0]    drop_q, drop_d;
  logic [SW-1:0]           drop_sum;
  logic                    pop, push_ok, grant_any;
  logic [CH_W-1:0]         grant_idx, idx;
  logic [NUM_CH-1:0]       grant, drop;

  assign full       = (level_q == LW'(DEPTH));
  assign empty      = (level_q == '0);
  assign out_valid  = ~empty;
  assign level      = level_q;
  assign drop_count = drop_q;
  assign pop        = out_valid & out_ready;
  assign push_ok    = ~full | pop;
  assign {out_ch, out_result} = mem_q[rd_ptr_q];

  // Round-robin search starting at rr_ptr; first pending channel wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = CH_W'((int'(rr_ptr_q) + k) % NUM_CH);
      if (push_ok && !grant_any && hold_v_q[idx]) begin
        grant_any = 1'b1;
        grant_idx = idx;
      end
    end
  end

  always_comb begin
    grant = '0;
    if (grant_any) grant[grant_idx] = 1'b1;
  end

  assign drop = done & hold_v_q & ~grant;

  always_comb begin
    drop_sum = {4'b0, drop_q};
    for (int i = 0; i < NUM_CH; i++) drop_sum = drop_sum + SW'(drop[i]);
    if (clear_drops)
      drop_d = '0;
    else if (drop_sum > {4'b0, {CNT_WIDTH{1'b1}}})
      drop_d = {CNT_WIDTH{1'b1}};
    else
      drop_d = drop_sum[CNT_WIDTH-1:0];
  end

  // A reload in the granted cycle keeps the channel pending.
  always_comb begin
    hold_v_d = hold_v_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (done[i] && !drop[i]) hold_v_d[i] = 1'b1;
      else if (grant[i])       hold_v_d[i] = 1'b0;
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_any) rr_ptr_d = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
  end

  always_comb begin
    level_d = level_q;
    case ({grant_any, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge alu_clk or negedge alu_rst) begin
    if (!alu_rst) begin
      hold_v_q <= '0;
      rr_ptr_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      drop_q   <= '0;
    end else begin
      hold_v_q <= hold_v_d;
      rr_ptr_q <= rr_ptr_d;
      level_q  <= level_d;
      drop_q   <= drop_d;
      if (grant_any) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)       rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge alu_clk) begin
    if (grant_any) mem_q[wr_ptr_q] <= {grant_idx, hold_d_q[grant_idx]};
    for (int i = 0; i < NUM_CH; i++) begin
      if (done[i] && !drop[i]) hold_d_q[i] <= result[i*RESULT_WIDTH +: RESULT_WIDTH];
    end
  end

endmodule
